// File: rtl/reorder_buffer_mc.sv
// Multi-channel reorder buffer: in-order allocation, CDB_N completion buses,
// up to COMMIT_W retirements per cycle, store handshake and branch/JALR redirect.
`timescale 1ns/1ps
module reorder_buffer_mc #(
   parameter int DEPTH    = 32,
   parameter int IDX_W    = $clog2(DEPTH),
   parameter int CDB_N    = 2,
   parameter int COMMIT_W = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     alloc_valid,
   input  logic [6:0]               alloc_type,
   input  logic [31:0]              alloc_pc,
   input  logic [4:0]               alloc_rd,
   input  logic [31:0]              alloc_value,
   input  logic [31:0]              alloc_imm,
   input  logic                     alloc_rvc,
   output logic                     alloc_ready,
   output logic [IDX_W-1:0]         alloc_id,
   output logic [IDX_W:0]           count,
   input  logic [IDX_W-1:0]         q_id_a,
   input  logic [IDX_W-1:0]         q_id_b,
   output logic                     q_rdy_a,
   output logic                     q_rdy_b,
   output logic [31:0]              q_val_a,
   output logic [31:0]              q_val_b,
   input  logic [CDB_N-1:0]         cdb_valid,
   input  logic [CDB_N*IDX_W-1:0]   cdb_id,
   input  logic [CDB_N*32-1:0]      cdb_value,
   output logic [COMMIT_W-1:0]      commit_valid,
   output logic [COMMIT_W-1:0]      commit_has_rd,
   output logic [COMMIT_W*IDX_W-1:0] commit_id,
   output logic [COMMIT_W*5-1:0]    commit_rd,
   output logic [COMMIT_W*32-1:0]   commit_value,
   output logic                     store_req,
   output logic [IDX_W-1:0]         store_id,
   input  logic                     store_ack,
   output logic                     flush,
   output logic                     redirect_valid,
   output logic [31:0]              redirect_pc
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   function automatic logic is_special(input logic [6:0] t);
      return (t == OP_STORE) || (t == OP_BRANCH) || (t == OP_JALR);
   endfunction

   function automatic logic writes_rd(input logic [6:0] t);
      return (t == OP_REG) || (t == OP_IMM) || (t == OP_LOAD) || (t == OP_JAL) ||
             (t == OP_JALR) || (t == OP_AUIPC) || (t == OP_LUI);
   endfunction

   logic [IDX_W-1:0] head, tail;
   logic [DEPTH-1:0] busy, done, rvc_q;
   logic [6:0]       type_q  [DEPTH];
   logic [4:0]       rd_q    [DEPTH];
   logic [31:0]      pc_q    [DEPTH];
   logic [31:0]      value_q [DEPTH];
   logic [31:0]      imm_q   [DEPTH];

   logic             do_alloc, head_ready, mispredict, jalr_commit;
   logic [1:0]       c_valid;
   logic [IDX_W-1:0] c_idx [2];
   logic [IDX_W:0]   n_commit;
   logic [CDB_N-1:0] cdb_live;
   logic [IDX_W-1:0] q_id   [2];
   logic [1:0]       q_hit, q_rdy;
   logic [31:0]      q_hval [2];
   logic [31:0]      q_val  [2];

   assign alloc_ready = count < (IDX_W+1)'(DEPTH);
   assign alloc_id    = tail;
   assign store_id    = head;
   assign do_alloc    = alloc_valid && alloc_ready;
   assign c_idx[0]    = head;
   assign c_idx[1]    = head + IDX_W'(1);
   assign n_commit    = (IDX_W+1)'(c_valid[0]) + (IDX_W+1)'(c_valid[1]);

   always_comb begin
      for (int c = 0; c < CDB_N; c++)
         cdb_live[c] = cdb_valid[c] && busy[cdb_id[c*IDX_W +: IDX_W]];
   end

   // Slot 1 may only follow a plain slot 0; stores, branches and JALR retire alone.
   always_comb begin
      head_ready  = busy[head] && done[head];
      store_req   = rdy_in && head_ready && (type_q[head] == OP_STORE);
      c_valid[0]  = rdy_in && head_ready && ((type_q[head] != OP_STORE) || store_ack);
      c_valid[1]  = (COMMIT_W == 2) && c_valid[0] && !is_special(type_q[head]) &&
                    busy[c_idx[1]] && done[c_idx[1]] && !is_special(type_q[c_idx[1]]);
      mispredict  = c_valid[0] && (type_q[head] == OP_BRANCH) &&
                    (rd_q[head][0] != value_q[head][0]);
      jalr_commit = c_valid[0] && (type_q[head] == OP_JALR);
      flush          = mispredict;
      redirect_valid = mispredict || jalr_commit;
      redirect_pc    = '0;
      if (jalr_commit)
         redirect_pc = imm_q[head];
      else if (mispredict)
         redirect_pc = pc_q[head] + (value_q[head][0] ? imm_q[head]
                                                      : (rvc_q[head] ? 32'd2 : 32'd4));
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      commit_valid  = '0;
      commit_has_rd = '0;
      commit_id     = '0;
      commit_rd     = '0;
      commit_value  = '0;
      for (int s = 0; s < COMMIT_W; s++) begin
         if (c_valid[s]) begin
            commit_valid[s]               = 1'b1;
            commit_has_rd[s]              = writes_rd(type_q[c_idx[s]]);
            commit_id[s*IDX_W +: IDX_W]   = c_idx[s];
            commit_rd[s*5 +: 5]           = rd_q[c_idx[s]];
            commit_value[s*32 +: 32]      = value_q[c_idx[s]];
         end
      end
   end

   // Query bypass takes the lowest matching channel; JALR keeps its link value.
   assign q_id[0] = q_id_a;
   assign q_id[1] = q_id_b;
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         q_hit[k]  = 1'b0;
         q_hval[k] = '0;
         for (int c = CDB_N-1; c >= 0; c--) begin
            if (cdb_valid[c] && (cdb_id[c*IDX_W +: IDX_W] == q_id[k])) begin
               q_hit[k]  = 1'b1;
               q_hval[k] = cdb_value[c*32 +: 32];
            end
         end
         q_rdy[k] = busy[q_id[k]] && (done[q_id[k]] || q_hit[k]);
         q_val[k] = (q_hit[k] && (type_q[q_id[k]] != OP_JALR)) ? q_hval[k] : value_q[q_id[k]];
      end
   end
   assign q_rdy_a = q_rdy[0];
   assign q_rdy_b = q_rdy[1];
   assign q_val_a = q_val[0];
   assign q_val_b = q_val[1];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         busy  <= '0;
         done  <= '0;
      end else if (rdy_in) begin
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
         end else begin
            if (do_alloc) begin
               busy[tail] <= 1'b1;
               done[tail] <= (alloc_type == OP_LUI) || (alloc_type == OP_JAL);
               tail       <= tail + IDX_W'(1);
            end
            for (int c = 0; c < CDB_N; c++)
               if (cdb_live[c]) done[cdb_id[c*IDX_W +: IDX_W]] <= 1'b1;
            for (int s = 0; s < 2; s++)
               if (c_valid[s]) busy[c_idx[s]] <= 1'b0;
            head  <= head + IDX_W'(n_commit);
            count <= count + (IDX_W+1)'(do_alloc) - n_commit;
         end
      end
   end

   // NOTE: payload storage has no reset; busy/done alone decide whether an entry is meaningful.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !flush) begin
         if (do_alloc) begin
            type_q[tail]  <= alloc_type;
            pc_q[tail]    <= alloc_pc;
            rd_q[tail]    <= alloc_rd;
            value_q[tail] <= alloc_value;
            imm_q[tail]   <= alloc_imm;
            rvc_q[tail]   <= alloc_rvc;
         end
         for (int c = 0; c < CDB_N; c++) begin
            if (cdb_live[c]) begin
               if (type_q[cdb_id[c*IDX_W +: IDX_W]] == OP_JALR)
                  imm_q[cdb_id[c*IDX_W +: IDX_W]]   <= cdb_value[c*32 +: 32];
               else
                  value_q[cdb_id[c*IDX_W +: IDX_W]] <= cdb_value[c*32 +: 32];
            end
         end
      end
   end

endmodule
